// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-period arithmetic,
// common to the receiver and the existing transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // Clocks per serial bit; integer division, so the baud error is truncated.
  function automatic int uart_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int uart_half(input int clk_freq, input int baud_rate);
    return uart_cycles(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; reset value is
// parameterized so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing (BIT data bits, LSB first, 1 stop bit),
// mid-bit sampling, valid/ready holding register, framing/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 20000000,
  parameter int BAUD_RATE = 57600,
  parameter int BIT       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_pin,
  output logic [BIT-1:0] rx_data,
  output logic           rx_data_valid,
  input  logic           rx_data_ready,
  output logic           frame_err,
  output logic           overrun
);

  localparam int          CYCLE     = uart_cycles(CLK_FREQ, BAUD_RATE);
  localparam int          HALF      = uart_half(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] CYC_LAST  = 32'(CYCLE - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(BIT - 1);

  logic rx_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

  uart_state_e    state_q, state_d;
  logic [31:0]    cycle_cnt_q, cycle_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [BIT-1:0] shift_q, shift_d;
  logic [BIT-1:0] rx_data_q, rx_data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           brk_q, brk_d;
  logic           done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      brk_q       <= brk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        // After a framing error the line must be seen high before re-arming.
        if (brk_q) begin
          if (rx_s) brk_d = 1'b0;
        end else if (!rx_s) begin
          state_d     = S_START;
          cycle_cnt_d = '0;
        end
      end
      S_START: begin
        bit_cnt_d = '0;
        if (cycle_cnt_q == HALF_LAST) begin
          cycle_cnt_d = '0;
          state_d     = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cycle_cnt_q == CYC_LAST) begin
          cycle_cnt_d = '0;
          for (int i = 0; i < BIT; i++)
            if (bit_cnt_q == 4'(i)) shift_d[i] = rx_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end
        end
      end
      S_STOP: begin
        bit_cnt_d = '0;
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (cycle_cnt_q == CYC_LAST) begin
          cycle_cnt_d = '0;
          state_d     = S_IDLE;
          if (rx_s) begin
            done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        cycle_cnt_d = '0;
        bit_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (done) begin
      // A same-edge read frees the register, so the new word can land.
      if (!valid_q || rx_data_ready) begin
        rx_data_d = shift_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 20 MHz / 57600 baud (347 clk/bit), 8 data bits.
module tb_uart_rx;

  localparam int BITLEN = 347;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx #(.CLK_FREQ(20000000), .BAUD_RATE(57600), .BIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Record accepted words and flag pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
      if (rx_data_valid) vld_cnt++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic clear_obs();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    vld_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit begins 1 time unit after the first posedge seen here.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx_pin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BITLEN) @(posedge clk);
      #1 rx_pin = b[i];
    end
    repeat (BITLEN) @(posedge clk);
    #1 rx_pin = stop_bit;
    repeat (BITLEN) @(posedge clk);
    #1 rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
    checks++;
    if (rx_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", rx_data_valid); end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got fe=%0b ov=%0b expected 0 0", frame_err, overrun);
    end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'hA5, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      failures++; $display("FAIL single_word: got n=%0d first=%0h expected n=1 a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++;
    if (vld_cnt != 1) begin failures++; $display("FAIL single_valid_width: got %0d cycles expected 1", vld_cnt); end
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin failures++; $display("FAIL single_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL b2b_count: got %0d expected 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h00 || got_q[1] !== 8'hFF) begin
        failures++; $display("FAIL b2b_order: got %0h %0h expected 00 ff", got_q[0], got_q[1]);
      end
    end
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin failures++; $display("FAIL b2b_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    clear_obs();
    @(posedge clk);
    #1 rx_pin = 1'b0;
    idle(100);
    rx_pin = 1'b1;
    idle(400);
    checks++;
    if (vld_cnt != 0 || fe_cnt != 0 || ov_cnt != 0) begin
      failures++; $display("FAIL glitch_quiet: got vld=%0d fe=%0d ov=%0d expected 0 0 0", vld_cnt, fe_cnt, ov_cnt);
    end
    send_frame(8'h3C, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      failures++; $display("FAIL glitch_next: got n=%0d first=%0h expected n=1 3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_framing();
    clear_obs();
    send_frame(8'h55, 1'b0);
    idle(300);
    checks++;
    if (fe_cnt != 1) begin failures++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cnt); end
    checks++;
    if (vld_cnt != 0 || got_q.size() != 0) begin
      failures++; $display("FAIL frame_err_discard: got vld=%0d n=%0d expected 0 0", vld_cnt, got_q.size());
    end
    send_frame(8'h12, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12 || fe_cnt != 1) begin
      failures++; $display("FAIL frame_err_next: got n=%0d first=%0h fe=%0d expected n=1 12 fe=1", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, fe_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    rx_data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(50);
    checks++;
    if (ov_cnt != 1) begin failures++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cnt); end
    checks++;
    if (rx_data !== 8'h11 || rx_data_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_hold: got %0h v=%0b expected 11 v=1", rx_data, rx_data_valid);
    end
    @(posedge clk);
    #1 rx_data_ready = 1'b1;
    @(posedge clk);
    #1 rx_data_ready = 1'b0;
    idle(5);
    checks++;
    if (got_q.size() != 1 || rx_data_valid !== 1'b0) begin
      failures++; $display("FAIL overrun_drain: got n=%0d v=%0b expected n=1 v=0", got_q.size(), rx_data_valid);
    end
    // Ready asserted only on the 0x22 stop-sample edge: E0 + 176 + 9*347.
    clear_obs();
    send_frame(8'h11, 1'b1);
    idle(20);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (3299) @(posedge clk);
        #1 rx_data_ready = 1'b1;
        @(posedge clk);
        #1 rx_data_ready = 1'b0;
      end
    join
    idle(50);
    checks++;
    if (rx_data !== 8'h22 || rx_data_valid !== 1'b1) begin
      failures++; $display("FAIL accept_swap: got %0h v=%0b expected 22 v=1", rx_data, rx_data_valid);
    end
    checks++;
    if (ov_cnt != 0 || got_q.size() != 1 || got_q[0] !== 8'h11) begin
      failures++; $display("FAIL accept_swap_flags: got ov=%0d n=%0d expected ov=0 n=1 (11)", ov_cnt, got_q.size());
    end
    rx_data_ready = 1'b1;
    idle(5);
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    rx_data_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(20);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (1900) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rx_data_valid !== 1'b0 || rx_data !== 8'h00) begin
          failures++; $display("FAIL rst_async: got %0h v=%0b expected 00 v=0", rx_data, rx_data_valid);
        end
      end
    join
    idle(5);
    rst = 1'b0;
    clear_obs();
    idle(400);
    checks++;
    if (vld_cnt != 0 || fe_cnt != 0 || ov_cnt != 0) begin
      failures++; $display("FAIL rst_quiet: got vld=%0d fe=%0d ov=%0d expected 0 0 0", vld_cnt, fe_cnt, ov_cnt);
    end
    rx_data_ready = 1'b1;
    send_frame(8'h99, 1'b1);
    idle(50);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h99) begin
      failures++; $display("FAIL rst_next: got n=%0d first=%0h expected n=1 99", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Basic UART receiver with configurable baud rate and word size; the receive-side counterpart of the existing UART transmitter.
- Samples the asynchronous serial pin and checks start and stop bits.
- Presents each received word on a valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the chip's RX pad and the on-chip consumer (CPU/peripheral bus bridge).

Parameters:
CLK_FREQ, 20000000, system clock frequency in Hz
BAUD_RATE, 57600, serial bit rate; CYCLE = CLK_FREQ / BAUD_RATE (integer division), HALF = CYCLE / 2
BIT, 8, data bits per frame (1..8); LSB first, no parity, 1 stop bit

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_pin  input  1  serial line; idles high; asynchronous to clk
rx_data  output  BIT  last accepted word; stable while rx_data_valid=1
rx_data_valid  output  1  holding register full
rx_data_ready  input  1  consumer accepts the word when rx_data_valid=1 and rx_data_ready=1 on the same clk edge
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: frame completed while the holding register was full and not being read

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, rx_data=0, rx_data_valid=0, frame_err=0, overrun=0, synchronizer flops=1 (line idle). Reset mid-frame aborts the frame; no output is produced.
- rx_pin passes through a 2-flop synchronizer; rx_s is the second flop. All logic uses rx_s only, so there is 2 cycles of input latency.
- cycle_cnt: 32 bits, cleared on every state change and on every sample point, otherwise +1.
- IDLE: if rx_s==0, go to START with cycle_cnt=0.
- START: at cycle_cnt==HALF-1, sample rx_s.
  - If 0: go to DATA, cycle_cnt=0, bit_cnt=0. This puts all later samples at mid-bit.
  - If 1: glitch; return to IDLE with no flags.
- DATA: at cycle_cnt==CYCLE-1, shift_reg[bit_cnt] <= rx_s and bit_cnt+1. After sampling bit BIT-1, go to STOP.
- STOP: at cycle_cnt==CYCLE-1, sample rx_s, then go to IDLE. Returning to IDLE at mid-stop-bit allows immediate detection of a back-to-back start bit.
  - rx_s==1: frame complete (see holding register rules).
  - rx_s==0: frame_err=1 for one cycle, word discarded, rx_data/rx_data_valid unchanged. IDLE does not re-trigger until rx_s has been 1 for at least one sample (break-condition guard).
- Holding register, evaluated on the frame-complete cycle; outputs update on the next edge:
  - rx_data_valid==0: load rx_data, set rx_data_valid=1.
  - rx_data_valid==1 and rx_data_ready==1: the old word is consumed and the new word loaded; rx_data_valid stays 1; no overrun.
  - rx_data_valid==1 and rx_data_ready==0: new word dropped, old word kept, overrun=1 for one cycle.
- Outside frame completion, rx_data_valid && rx_data_ready clears rx_data_valid on the next edge.
- Latency: rx_data_valid rises 1 clk after the stop-bit sample edge.
- bit_cnt is 4 bits, compared against BIT-1, and cleared outside DATA.

Decomposition:
- Shared package/header uart_pkg: state encodings S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3; the CYCLE/HALF computation macro. The existing transmitter shares the same encodings where applicable.
- One natural sub-module: sync_2ff (2-flop synchronizer with reset value parameter), reusable for other pad inputs.

Test Plan:
All scenarios use CLK_FREQ=20000000, BAUD_RATE=57600 (CYCLE=347, HALF=173), BIT=8, rx_data_ready=1 unless stated.
- Single frame: drive 0xA5 LSB-first at 347 clk/bit -> rx_data=0xA5, rx_data_valid high for 1 cycle (ready=1), frame_err=0, overrun=0.
- Back-to-back frames: 0x00 then 0xFF with only 1 stop bit between them -> both words received in order, no flags.
- Glitch: rx_pin low for 100 clk, then high -> no rx_data_valid and no flags, FSM back in IDLE; a following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit driven 0 -> frame_err pulses once, rx_data_valid stays 0. With the line then returned high, a following 0x12 frame is received correctly.
- Overrun and simultaneous accept:
  - ready=0: send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once.
  - Repeat with ready raised exactly on the 0x22 completion cycle -> rx_data=0x22, no overrun.
- Reset mid-frame: assert rst during data bit 4 of 0x77 -> outputs return to reset values immediately; no word or flag after release. A following 0x99 frame is received correctly.
